sdram_burst_engine: RTL and testbench

Responder to the FIFO coordinator's wr_strobe/rd_strobe. Sits between the input/output stream FIFOs and an Avalon-MM burst master port on the SDRAM controller. Each wr_strobe moves one fixed burst from the input FIFO into an SDRAM ring buffer; each rd_strobe moves one burst from the ring back into the output FIFO. sd_ready reports idle/busy back to the coordinator.

---
 rtl/sdram_burst_engine_pkg.sv | 15 +
 rtl/sdram_burst_engine_if.sv | 28 ++
 rtl/sdram_ring_ptr.sv | 60 ++++++
 rtl/sdram_burst_engine.sv | 148 ++++++++++++++
 tb/tb_sdram_burst_engine.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_burst_engine_pkg.sv
// Shared constants for the SDRAM burst engine: FSM encoding, default widths
// and the Avalon burstcount width.
package sdram_burst_engine_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 22;
    localparam int BURSTCOUNT_W = 9;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_BURST = 3'd1;
    localparam logic [2:0] ST_RD_CMD   = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/sdram_burst_engine_if.sv
// Avalon-MM burst master bundle between the burst engine (master) and the
// SDRAM controller (slave).
interface sdram_burst_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 22
);
    import sdram_burst_engine_pkg::*;

    logic [ADDR_W-1:0]       avm_address;
    logic [BURSTCOUNT_W-1:0] avm_burstcount;
    logic                    avm_write;
    logic [DATA_W-1:0]       avm_writedata;
    logic                    avm_read;
    logic                    avm_waitrequest;
    logic [DATA_W-1:0]       avm_readdata;
    logic                    avm_readdatavalid;

    modport master (
        output avm_address, avm_burstcount, avm_write, avm_writedata, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_burstcount, avm_write, avm_writedata, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/sdram_ring_ptr.sv
// Ring-buffer bookkeeping in units of bursts: write/read pointers, fill level
// and the SDRAM word address of the burst each pointer refers to.
module sdram_ring_ptr
    import sdram_burst_engine_pkg::*;
#(
    parameter int  ADDR_W      = ADDR_W_DEF,
    parameter int  BURST_LEN   = 64,
    parameter int  BASE_ADDR   = 0,
    parameter int  RING_BURSTS = 1024,
    localparam int PTR_W       = $clog2(RING_BURSTS),
    localparam int FILL_W      = PTR_W + 1
) (
    input  logic              sdram_clk,
    input  logic              reset,
    input  logic              wr_done,
    input  logic              rd_done,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [FILL_W-1:0] ring_fill
);

    localparam int OFF_SH = $clog2(BURST_LEN);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Pointers wrap naturally because RING_BURSTS is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_done);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_done);
        fill_d   = fill_q;
        if (wr_done && !rd_done) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (rd_done && !wr_done) begin
            fill_d = fill_q - FILL_W'(1);
        end
    end

    always_ff @(posedge sdram_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign full      = (fill_q == FILL_W'(RING_BURSTS));
    assign empty     = (fill_q == '0);
    assign wr_addr   = ADDR_W'(BASE_ADDR) + (ADDR_W'(wr_ptr_q) << OFF_SH);
    assign rd_addr   = ADDR_W'(BASE_ADDR) + (ADDR_W'(rd_ptr_q) << OFF_SH);
    assign ring_fill = fill_q;

endmodule

// File: rtl/sdram_burst_engine.sv
// Moves fixed-length bursts between the stream FIFOs and an SDRAM ring buffer
// on request of the FIFO coordinator (wr_strobe / rd_strobe).
module sdram_burst_engine
    import sdram_burst_engine_pkg::*;
#(
    parameter int  DATA_W      = DATA_W_DEF,
    parameter int  ADDR_W      = ADDR_W_DEF,
    parameter int  BURST_LEN   = 64,
    parameter int  BASE_ADDR   = 0,
    parameter int  RING_BURSTS = 1024,
    localparam int FILL_W      = $clog2(RING_BURSTS) + 1
) (
    input  logic                 sdram_clk,
    input  logic                 reset,
    input  logic                 wr_strobe,
    input  logic                 rd_strobe,
    output logic                 sd_ready,
    input  logic [DATA_W-1:0]    infifo_q,
    output logic                 infifo_rdreq,
    output logic [DATA_W-1:0]    outfifo_data,
    output logic                 outfifo_wrreq,
    sdram_burst_engine_if.master avm,
    output logic [FILL_W-1:0]    ring_fill,
    output logic                 overflow
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    logic [2:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              sd_ready_q, sd_ready_d;
    logic              overflow_q, overflow_d;
    logic              outfifo_wrreq_q, outfifo_wrreq_d;
    logic [DATA_W-1:0] outfifo_data_q, outfifo_data_d;

    logic              wr_accept, last_beat, wr_done, rd_done;
    logic              ring_full, ring_empty;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    sdram_ring_ptr #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .BASE_ADDR   (BASE_ADDR),
        .RING_BURSTS (RING_BURSTS)
    ) u_ring_ptr (
        .sdram_clk (sdram_clk),
        .reset     (reset),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .full      (ring_full),
        .empty     (ring_empty),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .ring_fill (ring_fill)
    );

    always_comb begin
        wr_accept  = (state_q == ST_WR_BURST) && !avm.avm_waitrequest;
        last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
        state_d    = state_q;
        beat_d     = beat_q;
        overflow_d = overflow_q;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous read request is dropped in favour of the write.
                if (wr_strobe) begin
                    if (ring_full) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d    = ST_WR_BURST;
                    end
                end else if (rd_strobe) begin
                    state_d = ring_empty ? ST_DONE : ST_RD_CMD;
                end
            end
            ST_WR_BURST: begin
                if (wr_accept) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        wr_done = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_RD_CMD: begin
                if (!avm.avm_waitrequest) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (avm.avm_readdatavalid) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        rd_done = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Registered so that it drops on the accepting edge and rises one
        // edge after the FSM is back in IDLE.
        sd_ready_d      = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        outfifo_wrreq_d = (state_q == ST_RD_DATA) && avm.avm_readdatavalid;
        outfifo_data_d  = avm.avm_readdatavalid ? avm.avm_readdata : outfifo_data_q;
    end

    always_ff @(posedge sdram_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            sd_ready_q      <= 1'b1;
            overflow_q      <= 1'b0;
            outfifo_wrreq_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            sd_ready_q      <= sd_ready_d;
            overflow_q      <= overflow_d;
            outfifo_wrreq_q <= outfifo_wrreq_d;
        end
    end

    always_ff @(posedge sdram_clk) begin
        outfifo_data_q <= outfifo_data_d;
    end

    assign sd_ready       = sd_ready_q;
    assign overflow       = overflow_q;
    assign outfifo_wrreq  = outfifo_wrreq_q;
    assign outfifo_data   = outfifo_data_q;
    assign infifo_rdreq   = wr_accept;

    assign avm.avm_write      = (state_q == ST_WR_BURST);
    assign avm.avm_read       = (state_q == ST_RD_CMD);
    assign avm.avm_writedata  = infifo_q;
    assign avm.avm_burstcount = BURSTCOUNT_W'(BURST_LEN);
    assign avm.avm_address    = (state_q == ST_WR_BURST) ? wr_addr :
                                (state_q == ST_RD_CMD)   ? rd_addr : '0;

endmodule

// File: tb/tb_sdram_burst_engine.sv
// Directed/randomized bench for sdram_burst_engine with a FIFO/SDRAM
// environment model and a burst-queue reference for the ring contents.
module tb_sdram_burst_engine;

    localparam int BL   = 64;
    localparam int RB   = 4;
    localparam int BASE = 0;
    localparam int DW   = 16;
    localparam int AW   = 22;

    typedef logic [DW-1:0] word_t;
    typedef word_t burst_t [BL];

    logic          sdram_clk = 1'b0;
    logic          reset     = 1'b0;
    logic          wr_strobe = 1'b0;
    logic          rd_strobe = 1'b0;
    logic          sd_ready;
    logic [DW-1:0] infifo_q  = '0;
    logic          infifo_rdreq;
    logic [DW-1:0] outfifo_data;
    logic          outfifo_wrreq;
    logic [2:0]    ring_fill;
    logic          overflow;

    sdram_burst_engine_if #(.DATA_W(DW), .ADDR_W(AW)) avm_if ();

    sdram_burst_engine #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .BASE_ADDR(BASE), .RING_BURSTS(RB)
    ) dut (
        .sdram_clk     (sdram_clk),
        .reset         (reset),
        .wr_strobe     (wr_strobe),
        .rd_strobe     (rd_strobe),
        .sd_ready      (sd_ready),
        .infifo_q      (infifo_q),
        .infifo_rdreq  (infifo_rdreq),
        .outfifo_data  (outfifo_data),
        .outfifo_wrreq (outfifo_wrreq),
        .avm           (avm_if.master),
        .ring_fill     (ring_fill),
        .overflow      (overflow)
    );

    always #5 sdram_clk = ~sdram_clk;

    // Reference model: bursts held in the ring, in write order.
    burst_t ring_ref[$];
    int     wr_idx = 0, rd_idx = 0;
    bit     exp_ovf = 1'b0;

    // Environment state.
    word_t   in_q[$];
    word_t   out_q[$];
    word_t   mem[int];
    bit      pop_pend = 0, pend_wr = 0, pend_rd = 0, stall_en = 0;
    int      rd_rem = 0, rd_beat = 0, rd_base = 0;
    logic    prev_write = 0, prev_read = 0, prev_wait = 0;
    logic [AW-1:0] prev_addr = '0;
    word_t   prev_wdata = '0;

    // Per-transaction observations.
    int wr_beats, rdreq_cnt, rdreq_err, wr_addr_err, stall_err;
    int read_cycles, read_cmds, rd_hold_err, low_cnt;
    logic [AW-1:0] cmd_addr, exp_wr_addr;

    int passed = 0, failed = 0, total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_beats = 0; rdreq_cnt = 0; rdreq_err = 0; wr_addr_err = 0; stall_err = 0;
        read_cycles = 0; read_cmds = 0; rd_hold_err = 0; low_cnt = 0; cmd_addr = '0;
        out_q.delete();
    endtask

    task automatic cycle();
        int k;
        @(negedge sdram_clk);
        wr_strobe = pend_wr;
        rd_strobe = pend_rd;
        pend_wr = 0;
        pend_rd = 0;
        if (pop_pend && in_q.size() > 0) void'(in_q.pop_front());
        pop_pend = 0;
        infifo_q = (in_q.size() > 0) ? in_q[0] : '0;
        if (rd_rem > 0 && $urandom_range(0, 3) != 0) begin
            k = rd_base + rd_beat;
            avm_if.avm_readdatavalid = 1'b1;
            avm_if.avm_readdata      = mem.exists(k) ? mem[k] : '0;
            rd_beat++;
            rd_rem--;
        end else begin
            avm_if.avm_readdatavalid = 1'b0;
            avm_if.avm_readdata      = word_t'($urandom);
        end
        avm_if.avm_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        #1;
        if (!sd_ready) low_cnt++;
        if (avm_if.avm_write) begin
            if (prev_write && prev_wait &&
                (avm_if.avm_address != prev_addr || avm_if.avm_writedata != prev_wdata))
                stall_err++;
            if (!avm_if.avm_waitrequest) begin
                if (avm_if.avm_address != exp_wr_addr) wr_addr_err++;
                mem[int'(avm_if.avm_address) + wr_beats] = avm_if.avm_writedata;
                wr_beats++;
            end
        end
        if (infifo_rdreq) begin
            rdreq_cnt++;
            pop_pend = 1;
        end
        if (infifo_rdreq != (avm_if.avm_write && !avm_if.avm_waitrequest)) rdreq_err++;
        if (prev_read && prev_wait && (!avm_if.avm_read || avm_if.avm_address != prev_addr))
            rd_hold_err++;
        if (avm_if.avm_read) begin
            read_cycles++;
            if (!avm_if.avm_waitrequest) begin
                read_cmds++;
                cmd_addr = avm_if.avm_address;
                rd_rem   = BL;
                rd_beat  = 0;
                rd_base  = int'(avm_if.avm_address);
            end
        end
        if (outfifo_wrreq) out_q.push_back(outfifo_data);
        prev_write = avm_if.avm_write;
        prev_read  = avm_if.avm_read;
        prev_wait  = avm_if.avm_waitrequest;
        prev_addr  = avm_if.avm_address;
        prev_wdata = avm_if.avm_writedata;
    endtask

    task automatic run_txn(input bit w, input bit r, input int inj_rd_at, input string tag);
        bit done = 0;
        clear_mon();
        pend_wr = w;
        pend_rd = r;
        cycle();
        low_cnt = 0;
        for (int i = 1; i <= 3000; i++) begin
            if (i == inj_rd_at) pend_rd = 1;
            cycle();
            if (sd_ready) begin
                done = 1;
                break;
            end
        end
        check({tag, "/completes"}, 32'(done), 32'd1);
    endtask

    task automatic write_txn(input bit seq, input bit stall, input bit both, input int inj,
                             input string tag);
        burst_t b;
        bit     full;
        int     derr = 0;
        for (int i = 0; i < BL; i++) b[i] = seq ? word_t'(i) : word_t'($urandom);
        for (int i = 0; i < BL; i++) in_q.push_back(b[i]);
        full        = (ring_ref.size() == RB);
        exp_wr_addr = AW'(BASE + (wr_idx % RB) * BL);
        stall_en    = stall;
        run_txn(1'b1, both, inj, tag);
        stall_en    = 0;
        if (full) begin
            exp_ovf = 1'b1;
            check({tag, "/beats"}, 32'(wr_beats), 32'd0);
            check({tag, "/low_cycles"}, 32'(low_cnt), 32'd2);
            in_q.delete();
            pop_pend = 0;
        end else begin
            check({tag, "/beats"}, 32'(wr_beats), 32'(BL));
            check({tag, "/rdreq"}, 32'(rdreq_cnt), 32'(BL));
            check({tag, "/addr"}, 32'(wr_addr_err), 32'd0);
            check({tag, "/stall_stable"}, 32'(stall_err), 32'd0);
            check({tag, "/rdreq_comb"}, 32'(rdreq_err), 32'd0);
            for (int i = 0; i < BL; i++) begin
                int k = int'(exp_wr_addr) + i;
                if (!mem.exists(k) || mem[k] !== b[i]) derr++;
            end
            check({tag, "/data"}, 32'(derr), 32'd0);
            ring_ref.push_back(b);
            wr_idx++;
        end
        check({tag, "/no_read"}, 32'(read_cycles), 32'd0);
        check({tag, "/ring_fill"}, 32'(ring_fill), 32'(ring_ref.size()));
        check({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic read_txn(input bit stall, input string tag);
        bit            empty;
        int            derr = 0;
        logic [AW-1:0] exp_addr;
        empty    = (ring_ref.size() == 0);
        exp_addr = AW'(BASE + (rd_idx % RB) * BL);
        stall_en = stall;
        run_txn(1'b0, 1'b1, 0, tag);
        stall_en = 0;
        if (empty) begin
            check({tag, "/no_read"}, 32'(read_cycles), 32'd0);
            check({tag, "/low_cycles"}, 32'(low_cnt), 32'd2);
        end else begin
            check({tag, "/cmds"}, 32'(read_cmds), 32'd1);
            check({tag, "/addr"}, 32'(cmd_addr), 32'(exp_addr));
            check({tag, "/cmd_held"}, 32'(rd_hold_err), 32'd0);
            check({tag, "/words"}, 32'(out_q.size()), 32'(BL));
            for (int i = 0; i < BL; i++)
                if (i >= out_q.size() || out_q[i] !== ring_ref[0][i]) derr++;
            check({tag, "/data"}, 32'(derr), 32'd0);
            void'(ring_ref.pop_front());
            rd_idx++;
        end
        check({tag, "/no_write"}, 32'(wr_beats), 32'd0);
        check({tag, "/ring_fill"}, 32'(ring_fill), 32'(ring_ref.size()));
        check({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        avm_if.avm_waitrequest   = 1'b0;
        avm_if.avm_readdata      = '0;
        avm_if.avm_readdatavalid = 1'b0;

        // Power-on reset.
        repeat (3) @(negedge sdram_clk);
        #1;
        check("rst/sd_ready", 32'(sd_ready), 32'd1);
        check("rst/avm_write", 32'(avm_if.avm_write), 32'd0);
        check("rst/avm_read", 32'(avm_if.avm_read), 32'd0);
        @(negedge sdram_clk);
        reset = 1'b1;
        #1;
        check("rst/sd_ready_after", 32'(sd_ready), 32'd1);
        check("rst/rdreq", 32'(infifo_rdreq), 32'd0);
        check("rst/wrreq", 32'(outfifo_wrreq), 32'd0);
        check("rst/ring_fill", 32'(ring_fill), 32'd0);
        check("rst/overflow", 32'(overflow), 32'd0);
        check("rst/burstcount", 32'(avm_if.avm_burstcount), 32'(BL));

        read_txn(1'b0, "empty_read");
        write_txn(1'b1, 1'b0, 1'b0, 0, "wr_seq");
        read_txn(1'b0, "rd_seq");
        write_txn(1'b0, 1'b1, 1'b0, 0, "wr_stall");
        read_txn(1'b1, "rd_stall");
        write_txn(1'b0, 1'b0, 1'b0, 0, "wr_pre_reset");

        // Reset asserted in the middle of a write burst.
        for (int i = 0; i < BL; i++) in_q.push_back(word_t'($urandom));
        exp_wr_addr = AW'(BASE + (wr_idx % RB) * BL);
        clear_mon();
        pend_wr = 1;
        cycle();
        for (int i = 0; i < 500 && wr_beats < 30; i++) cycle();
        check("midrst/reached_beat30", 32'(wr_beats), 32'd30);
        reset = 1'b0;
        #1;
        check("midrst/avm_write", 32'(avm_if.avm_write), 32'd0);
        check("midrst/rdreq", 32'(infifo_rdreq), 32'd0);
        check("midrst/sd_ready", 32'(sd_ready), 32'd1);
        check("midrst/ring_fill", 32'(ring_fill), 32'd0);
        @(negedge sdram_clk);
        reset = 1'b1;
        ring_ref.delete();
        in_q.delete();
        wr_idx = 0; rd_idx = 0; exp_ovf = 0; pop_pend = 0; rd_rem = 0;
        prev_write = 0; prev_read = 0; prev_wait = 0;

        // Fill the ring, overflow it, drain it, then wrap.
        for (int n = 0; n < RB; n++) write_txn(1'b0, 1'b1, 1'b0, 0, $sformatf("fill%0d", n));
        write_txn(1'b0, 1'b0, 1'b0, 0, "wr_full");
        for (int n = 0; n < RB; n++) read_txn(1'b1, $sformatf("drain%0d", n));
        write_txn(1'b0, 1'b0, 1'b0, 0, "wr_wrap");
        read_txn(1'b0, "rd_wrap");

        // Protocol edges.
        write_txn(1'b0, 1'b0, 1'b1, 0, "wr_rd_same");
        write_txn(1'b0, 1'b0, 1'b0, 5, "rd_during_wr");
        read_txn(1'b0, "rd_edge0");
        read_txn(1'b0, "rd_edge1");
        read_txn(1'b0, "rd_empty_end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
